mips_data_mem_responder: RTL

- Memory-side responder for the MIPS32 pipeline's MEM stage: word-addressed, single-port data memory behind a valid/ready request/response handshake.
- Serves LW/SW-style accesses with a per-request programmable wait-state count, so the pipeline can be tested against slow memory.
- Flags out-of-range addresses instead of aliasing them.
- Sits between the pipeline (initiator) and the data memory array; one outstanding transaction at a time.

---
 rtl/mips_data_mem_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/mips_data_mem_responder.sv
// MEM-stage data memory responder: word-addressed single-port array
// behind valid/ready request and response handshakes, with wait states.
module mips_data_mem_responder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        cfg_wait,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;
   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign in_range  = addr_q < ADDR_W'(DEPTH);
   assign idx       = addr_q[IDX_W-1:0];
   assign req_ready = (state == S_IDLE) && !rst;
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

   // Every accept passes through WAIT once, so the response lands
   // exactly cfg_wait+2 edges after the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cnt     <= cfg_wait;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_ACCESS;
               else             cnt   <= cnt - 4'd1;
            end
            S_ACCESS: begin
               rsp_err   <= !in_range;
               rsp_rdata <= (!we_q && in_range) ? mem[idx] : '0;
               state     <= S_RESP;
            end
            default: begin
               if (rsp_ready) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Array has no reset; a reset during ACCESS must still block the write.
   always_ff @(posedge clk) begin
      if (!rst && state == S_ACCESS && we_q && in_range)
         mem[idx] <= wdata_q;
   end

endmodule
